store_buffer: RTL and testbench
===============================

# store_buffer

Write buffer between the execute stage and the 8-word, 32-bit data memory. Posts stores into a small FIFO and drains them into memory, one per cycle, when the single memory port is free. Serves loads with a fixed 1-cycle latency: from the youngest matching buffered store, or from memory on a miss. Lets stores retire without waiting on the memory port while loads always see program-order data.

## Interface
- DEPTH, 4: store FIFO entries, power of two, at least 2.
- ADDR_W, 3: word address width, matching the data memory's 8 words.
- DATA_W, 32: data width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_adr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  request accepted this cycle (combinational).
- mem_hold  in  1  memory port unavailable: no memory access may be issued.
- load_valid  out  1  load result valid (registered).
- load_data  out  DATA_W  load result.
- mem_adr  out  ADDR_W  memory address.
- mem_writeIn  out  DATA_W  memory write data.
- mem_writePin  out  1  memory write enable.
- mem_readPin  out  1  memory read enable.
- mem_readOut  in  DATA_W  memory read data, registered inside memory, valid the cycle after mem_readPin.
- count  out  clog2(DEPTH)+1  occupied entries.
- empty  out  1  count == 0; stage control uses this for fences and halt.

## Operation
- FIFO: head and tail pointers wrap modulo DEPTH; count is tracked separately; full = (count == DEPTH).
- Hit: an accepted load hits when any valid entry's address equals req_adr. Forwarded data comes from the youngest matching entry, searched from tail-1 backward.
- Port arbitration, evaluated each cycle, first match wins:
  - mem_hold = 1: no access; mem_writePin = mem_readPin = 0.
  - full and count > 0: drain the head entry.
  - Accepted load miss: mem_readPin = 1, mem_adr = req_adr.
  - count > 0: drain the head entry.
  - Otherwise idle.
- Drain: mem_writePin = 1, mem_adr and mem_writeIn taken from the head entry; head advances at the edge.
- req_ready:
  - Store: count < DEPTH, or (full and a drain occurs this cycle) — not allowed; a store when full waits.
  - Load hit: always 1.
  - Load miss: 1 only if that load wins the port under the rules above.
- Store enqueue and head drain in the same cycle leave count unchanged. A store enqueued in cycle N is forwardable from cycle N+1. A store accepted with count 0 is not drained in the same cycle.
- Stores do not coalesce: a second store to the same address takes a new entry, and both are written to memory in order.
- Idle outputs: mem_adr = 0, mem_writeIn = 0.

## Timing
- Load latency is exactly 1 cycle: a load accepted in cycle N gives load_valid = 1 in cycle N+1, for one cycle.
- load_data in cycle N+1:
  - Hit: the forwarding register captured at edge N.
  - Miss: mem_readOut, passed straight through.
  - load_data holds its last value when load_valid = 0.
- Store accepted in cycle N: written to memory no earlier than cycle N+1.
- Ordering: a load miss issued in the same cycle as a pending drain to a different address is safe, because hits never go to memory.
- Reset, registered values: count = 0, head = tail = 0, all entries invalid, load_valid = 0, load_data = 0.
- Reset, combinational values: mem_writePin = mem_readPin = 0 and req_ready = 0 while reset is high.
- Reset mid-operation discards buffered stores and cancels a pending load_valid.

## Test plan
- Store 0xDEADBEEF to adr 5 from reset, no further requests.
  - Next cycle: mem_writePin = 1, mem_adr = 5, mem_writeIn = 0xDEADBEEF.
  - count goes 1 → 0; empty returns to 1.
- Stores of adr 2 = 0x11 and adr 2 = 0x22 in consecutive cycles with mem_hold = 1, then a load of adr 2.
  - One cycle later: load_valid = 1, load_data = 0x22.
  - mem_readPin never asserted.
- Memory preloaded with adr 6 = 0x0A; empty buffer; load of adr 6.
  - mem_readPin = 1 and mem_adr = 6 in the same cycle.
  - Next cycle: load_valid = 1, load_data = 0x0A.
- mem_hold = 1 and four stores to adr 0..3: count = 4 and req_ready = 0 for a fifth store.
  - A load miss to adr 7 is stalled.
  - Releasing mem_hold: drains of adr 0, 1, 2, 3 in order, one per cycle. The stalled load issues once count < 4.
- Buffer holding 3 stores, then reset asserted for one cycle.
  - count = 0, no further mem_writePin.
  - A load of a previously buffered address returns the memory value.
- Wrap-around: 10 stores with alternating hold so the pointers wrap twice.
  - Memory receives all 10 in issue order.
  - Loads after each store forward the latest value.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO in front of a single-port data memory.
// Stores drain one per cycle when the port is free. Loads complete in one
// cycle, forwarded from the youngest matching buffered store or read from memory.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_adr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     req_ready,
  input  logic                     mem_hold,
  output logic                     load_valid,
  output logic [DATA_W-1:0]        load_data,
  output logic [ADDR_W-1:0]        mem_adr,
  output logic [DATA_W-1:0]        mem_writeIn,
  output logic                     mem_writePin,
  output logic                     mem_readPin,
  input  logic [DATA_W-1:0]        mem_readOut,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ent_adr  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              full;
  logic              miss_go;
  logic              drain;
  logic              store_acc;
  logic              load_acc;

  logic              hit_q;
  logic [DATA_W-1:0] fwd_q;
  logic [DATA_W-1:0] last_q;
  logic              load_valid_q;

  // Youngest-first match search, starting at tail-1 and walking backward
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit && ent_valid[tail - PTR_W'(i + 1)] &&
          ent_adr[tail - PTR_W'(i + 1)] == req_adr) begin
        hit      = 1'b1;
        hit_data = ent_data[tail - PTR_W'(i + 1)];
      end
    end
  end

  // Port arbitration: full buffer drains first, then a load miss, then a drain
  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    miss_go   = !reset && req_valid && !req_write && !hit && !mem_hold && !full;
    drain     = !reset && !mem_hold && (count != '0) && !miss_go;
    req_ready = !reset && req_valid && (req_write ? !full : (hit || miss_go));
    store_acc = req_ready && req_write;
    load_acc  = req_ready && !req_write;
  end

  // Memory port drive; address and data are zero when idle
  always_comb begin
    mem_writePin = drain;
    mem_readPin  = miss_go;
    mem_adr      = '0;
    mem_writeIn  = '0;
    if (drain) begin
      mem_adr     = ent_adr[head];
      mem_writeIn = ent_data[head];
    end else if (miss_go) begin
      mem_adr = req_adr;
    end
  end

  // Entry payload storage; validity is tracked separately with reset
  always_ff @(posedge clk) begin
    if (store_acc) begin
      ent_adr[tail]  <= req_adr;
      ent_data[tail] <= req_wdata;
    end
  end

  // FIFO pointers, occupancy and validity
  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (store_acc) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(store_acc) - CNT_W'(drain);
    end
  end

  // Load response pipeline: forwarding capture and last-result hold
  always_ff @(posedge clk) begin
    if (reset) begin
      load_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      fwd_q        <= '0;
      last_q       <= '0;
    end else begin
      load_valid_q <= load_acc;
      if (load_acc) begin
        hit_q <= hit;
        fwd_q <= hit_data;
      end
      if (load_valid_q) begin
        last_q <= load_data;
      end
    end
  end

  // Miss data passes straight through from the memory's read register
  always_comb begin
    load_valid = load_valid_q;
    load_data  = last_q;
    if (load_valid_q) begin
      load_data = hit_q ? fwd_q : mem_readOut;
    end
    empty = (count == '0);
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected loads and memory writes are
// queued at acceptance and popped by a monitor when the DUT presents them.
module tb_store_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              mem_hold;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_writeIn;
  logic              mem_writePin;
  logic              mem_readPin;
  logic [DATA_W-1:0] mem_readOut;
  logic [2:0]        count;
  logic              empty;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_adr(req_adr),
    .req_wdata(req_wdata), .req_ready(req_ready), .mem_hold(mem_hold),
    .load_valid(load_valid), .load_data(load_data),
    .mem_adr(mem_adr), .mem_writeIn(mem_writeIn),
    .mem_writePin(mem_writePin), .mem_readPin(mem_readPin),
    .mem_readOut(mem_readOut), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Data memory model with a preload port
  logic [31:0] mem [8];
  logic        pre_en;
  logic [2:0]  pre_adr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_adr] <= pre_data;
    else if (mem_writePin) mem[mem_adr] <= mem_writeIn;
    if (mem_readPin) mem_readOut <= mem[mem_adr];
  end

  logic [31:0] lq [$];
  logic [34:0] wq [$];
  logic [34:0] we;
  logic [31:0] le;
  int checks = 0;
  int errors = 0;
  int reads_seen = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string n);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, expected none at %0t", n, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result or write
  always @(negedge clk) begin
    if (mem_readPin) reads_seen++;
    if (load_valid) begin
      if (lq.size() == 0) fail_evt("load_unexpected");
      else begin
        le = lq.pop_front();
        chk("load_data", load_data, le);
      end
    end
    if (mem_writePin) begin
      if (wq.size() == 0) fail_evt("write_unexpected");
      else begin
        we = wq.pop_front();
        chk("wr_adr", 32'(mem_adr), 32'(we[34:32]));
        chk("wr_data", mem_writeIn, we[31:0]);
      end
    end
  end

  // Issue one request, waiting for acceptance; exp_wait < 0 skips the stall check
  task automatic req(input logic w, input logic [2:0] a, input logic [31:0] d,
                     input logic [31:0] exp_ld, input logic exp_rd, input int exp_wait);
    int waited = 0;
    bit done = 1'b0;
    req_valid = 1'b1; req_write = w; req_adr = a; req_wdata = d;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        if (w) wq.push_back({a, d});
        else lq.push_back(exp_ld);
        if (exp_rd) begin
          chk("rd_pin", 32'(mem_readPin), 32'd1);
          chk("rd_adr", 32'(mem_adr), 32'(a));
        end
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) fail_evt("req_timeout");
    else if (exp_wait >= 0) chk("req_wait", 32'(waited), 32'(exp_wait));
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    logic [2:0] a;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_adr = '0;
    req_wdata = '0; mem_hold = 1'b0; pre_en = 1'b0; pre_adr = '0; pre_data = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      pre_en = 1'b1; pre_adr = 3'(i);
      pre_data = (i == 6) ? 32'h0A : (i == 7) ? 32'h77 : 32'h50 + 32'(i);
      @(posedge clk); #1;
    end
    pre_en = 1'b0;

    // Reset state, with a store presented while reset is high
    req_valid = 1'b1; req_write = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wpin", 32'(mem_writePin), 32'd0);
    chk("rst_rpin", 32'(mem_readPin), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_lvalid", 32'(load_valid), 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b0;

    // Single store from reset drains the next cycle
    req(1'b1, 3'd5, 32'hDEADBEEF, '0, 1'b0, 0);
    @(negedge clk);
    chk("t1_count1", 32'(count), 32'd1);
    chk("t1_wpin", 32'(mem_writePin), 32'd1);
    @(posedge clk); #1;
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);

    // Two stores to one address under hold; load forwards the younger
    mem_hold = 1'b1;
    r0 = reads_seen;
    req(1'b1, 3'd2, 32'h11, '0, 1'b0, 0);
    req(1'b1, 3'd2, 32'h22, '0, 1'b0, 0);
    req(1'b0, 3'd2, '0, 32'h22, 1'b0, 0);
    idle(1);
    chk("t2_noread", 32'(reads_seen), 32'(r0));
    chk("t2_count", 32'(count), 32'd2);
    mem_hold = 1'b0;
    idle(3);
    chk("t2_empty", 32'(empty), 32'd1);

    // Load miss from memory, then load_data holds
    req(1'b0, 3'd6, '0, 32'h0A, 1'b1, 0);
    idle(1);
    @(negedge clk);
    chk("t3_lvalid0", 32'(load_valid), 32'd0);
    chk("t3_hold", load_data, 32'h0A);
    @(posedge clk); #1;

    // Fill under hold, stalled store and load miss, ordered drains on release
    mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) req(1'b1, 3'(i), 32'h100 + 32'(i), '0, 1'b0, 0);
    chk("t4_count4", 32'(count), 32'd4);
    req_valid = 1'b1; req_write = 1'b1; req_adr = 3'd4; req_wdata = 32'h999;
    @(negedge clk);
    chk("t4_full_store", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_write = 1'b0; req_adr = 3'd7;
    @(negedge clk);
    chk("t4_held_load", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    mem_hold = 1'b0;
    req(1'b0, 3'd7, '0, 32'h77, 1'b1, 1);
    idle(5);
    chk("t4_empty", 32'(empty), 32'd1);

    // Reset discards buffered stores
    mem_hold = 1'b1;
    req(1'b1, 3'd4, 32'hA4, '0, 1'b0, 0);
    req(1'b1, 3'd2, 32'hB2, '0, 1'b0, 0);
    req(1'b1, 3'd6, 32'hC6, '0, 1'b0, 0);
    chk("t5_count3", 32'(count), 32'd3);
    reset = 1'b1;
    wq.delete();
    @(negedge clk);
    chk("t5_rst_wpin", 32'(mem_writePin), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_hold = 1'b0;
    chk("t5_count0", 32'(count), 32'd0);
    idle(3);
    req(1'b0, 3'd4, '0, 32'h54, 1'b1, 0);
    req(1'b0, 3'd2, '0, 32'h102, 1'b1, 0);
    idle(2);

    // Ten stores with alternating hold, each followed by a forwarding load
    for (int i = 0; i < 10; i++) begin
      mem_hold = (i % 2) == 1;
      a = 3'((i * 3) % 8);
      req(1'b1, a, 32'hC000 + 32'(i), '0, 1'b0, -1);
      req(1'b0, a, '0, 32'hC000 + 32'(i), 1'b0, 0);
    end
    mem_hold = 1'b0;
    idle(8);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("lq_drained", 32'(lq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
